// File: rtl/piso_bit_source_pkg.sv
`default_nettype none
// piso_bit_source_pkg: shared state encoding, default sizes and the detector pattern.
package piso_bit_source_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 5;

  localparam logic [3:0] DETECT_PATTERN = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/piso_bit_source_counter.sv
`default_nettype none
// piso_bit_counter: bit index within the current word, saturating at WIDTH-1.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_bit_source.sv
`default_nettype none
// piso_bit_source: loads a word over valid/ready and serialises it one bit per
// clock on x, with pause (shift_en), per-word bit order and gapless back-to-back.
module piso_bit_source
  import piso_bit_source_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] ordered;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             accept;
  logic             advance;

  // The word is stored so that emission is always MSB-first out of sreg;
  // an LSB-first request is handled by reversing it at load time.
  always_comb begin
    ordered = load_data;
    if (!msb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        ordered[i] = load_data[WIDTH-1-i];
      end
    end
  end

  assign advance    = (state == ST_SHIFT) && shift_en;
  assign load_ready = (state == ST_IDLE) || (advance && last);
  assign accept     = load_valid && load_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept || (advance && last)),
    .enable (advance),
    .count  (count),
    .last   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else if (accept) begin
      state   <= ST_SHIFT;
      sreg    <= ordered;
      x       <= ordered[WIDTH-1];
      x_valid <= 1'b1;
      done    <= 1'b0;
    end else if (advance) begin
      if (last) begin
        state   <= ST_IDLE;
        x       <= 1'b0;
        x_valid <= 1'b0;
        done    <= 1'b0;
      end else begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        x    <= sreg[WIDTH-2];
        // The bit being presented next is the last one of the word.
        done <= (count == CNT_W'(WIDTH - 2));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_source.sv
`default_nettype none
// tb_piso_bit_source: directed and random stimulus against a queue-based model
// of the serial stream.
module tb_piso_bit_source;
  import piso_bit_source_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         msb_first = 1'b1;
  logic         shift_en = 1'b1;
  logic         load_ready, x, x_valid, done;

  int checks = 0;
  int errors = 0;

  bit model_q[$];
  bit log_q[$];

  always #5 clk = ~clk;

  piso_bit_source #(.WIDTH(W), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .msb_first  (msb_first),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .x          (x),
    .x_valid    (x_valid),
    .done       (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, check, then apply the model
  // update at the rising edge.
  task automatic cycle(input bit lv, input logic [W-1:0] d, input bit msb, input bit se);
    bit exp_ready;
    bit acc;
    load_valid = lv;
    load_data  = d;
    msb_first  = msb;
    shift_en   = se;
    #1;
    exp_ready = (model_q.size() == 0) || (model_q.size() == 1 && se);
    check("x_valid", int'(x_valid), int'(model_q.size() != 0));
    check("x", int'(x), model_q.size() != 0 ? int'(model_q[0]) : 0);
    check("done", int'(done), int'(model_q.size() == 1));
    check("load_ready", int'(load_ready), int'(exp_ready));
    if (x_valid && se) log_q.push_back(x);
    acc = lv && exp_ready;
    @(posedge clk);
    if (model_q.size() != 0 && se) void'(model_q.pop_front());
    if (acc) begin
      for (int k = 0; k < W; k++) model_q.push_back(msb ? d[W-1-k] : d[k]);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_x", int'(x), 0);
    check("rst_x_valid", int'(x_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_load_ready", int'(load_ready), 1);
    model_q.delete();
    load_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_x_valid", int'(x_valid), 0);
    load_valid = 1'b0;
    reset = 1'b0;
  endtask

  function automatic int count_pattern(input bit s[$]);
    int n = 0;
    logic [3:0] win = '0;
    for (int i = 0; i < s.size(); i++) begin
      win = {win[2:0], s[i]};
      if (i >= 3 && win == DETECT_PATTERN) n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] log_word();
    logic [15:0] v = '0;
    for (int i = 0; i < log_q.size() && i < 16; i++) v = {v[14:0], log_q[i]};
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Reset and idle
    async_reset();
    idle(4);

    // MSB-first word
    log_q.delete();
    cycle(1'b1, 8'b1101_1010, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("msb_stream", int'(log_word()), int'(8'b1101_1010));
    check("msb_detections", count_pattern(log_q), 2);

    // LSB-first word yields the same stream
    log_q.delete();
    cycle(1'b1, 8'b0101_1011, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("lsb_stream", int'(log_word()), int'(8'b1101_1010));

    // Back-to-back words
    log_q.delete();
    cycle(1'b1, 8'hD0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'hD0, 1'b1, 1'b1);
    cycle(1'b1, 8'h0F, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("b2b_len", log_q.size(), 16);
    check("b2b_stream", int'(log_word()), int'(16'b1101_0000_0000_1111));

    // Pause after bit 2 of 8'hB5
    log_q.delete();
    cycle(1'b1, 8'hB5, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("pause_stream", int'(log_word()), int'(8'hB5));

    // Abort during bit 5
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    async_reset();
    idle(2);
    log_q.delete();
    cycle(1'b1, 8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("post_abort_stream", int'(log_word()), int'(8'h69));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 8));
      if (i == 250) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
